// File: rtl/ksa_pkg.sv
// Shared types and helpers for the RC4-style key-scheduling engine and its consumers.
package ksa_pkg;

    localparam int unsigned DefAddrW    = 8;
    localparam int unsigned DefKeyBytes = 3;

    // Widest key / element the shared extraction helper can serve.
    localparam int unsigned KeyMaxBits = 4096;
    localparam int unsigned ElemMaxW   = 16;

    typedef enum logic [3:0] {
        StIdle,
        StInit,
        StSwRi,
        StSwLi,
        StSwRj,
        StSwLj,
        StSwWi,
        StSwWj,
        StDone
    } state_e;

    // Element 0 sits in the most significant bits of the key.
    function automatic logic [ElemMaxW-1:0] key_elem(
        input logic [KeyMaxBits-1:0] key,
        input int unsigned           key_bytes,
        input int unsigned           elem_w,
        input int unsigned           k
    );
        return ElemMaxW'(key >> ((key_bytes - 1 - k) * elem_w));
    endfunction

endpackage

// File: rtl/ksa_sched_if.sv
// Single-port S-memory bus between the key scheduler (master) and the RAM (slave).
interface ksa_sched_if #(
    parameter int unsigned ADDR_W = ksa_pkg::DefAddrW
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] mem_wr_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_rd_data;

    modport master (
        output mem_addr,
        output mem_wr_data,
        output mem_wr_en,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_data,
        input  mem_wr_en,
        output mem_rd_data
    );

endinterface

// File: rtl/ksa_key_sel.sv
// Combinational key element selector: returns element k of a packed key.
module ksa_key_sel
    import ksa_pkg::*;
#(
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned KEY_BYTES = DefKeyBytes,
    localparam int unsigned KeyIdxW  = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
    input  logic [KEY_BYTES*ADDR_W-1:0] key_i,
    input  logic [KeyIdxW-1:0]          k_i,
    output logic [ADDR_W-1:0]           elem_o
);

    // Only the low ADDR_W bits of the wide helper result are meaningful.
    logic [ElemMaxW-1:0] elem_wide_unused;

    assign elem_wide_unused = key_elem(KeyMaxBits'(key_i), KEY_BYTES, ADDR_W, 32'(k_i));
    assign elem_o           = elem_wide_unused[ADDR_W-1:0];

endmodule

// File: rtl/ksa_sched.sv
// RC4-style key scheduler: optional S[i]=i init, then the j/swap loop over a
// single-port synchronous S-memory. All outputs are registered.
module ksa_sched
    import ksa_pkg::*;
#(
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned KEY_BYTES = DefKeyBytes,
    localparam int unsigned KeyIdxW  = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        skip_init,
    input  logic [KEY_BYTES*ADDR_W-1:0] key,
    output logic                        busy,
    output logic                        done,
    ksa_sched_if.master                 mem
);

    state_e                      state_q, state_d;
    logic [ADDR_W-1:0]           i_q, i_d;
    logic [ADDR_W-1:0]           j_q, j_d;
    logic [ADDR_W-1:0]           si_q, si_d;
    logic [KeyIdxW-1:0]          k_q, k_d;
    logic [KEY_BYTES*ADDR_W-1:0] key_q, key_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [ADDR_W-1:0]           wdata_q, wdata_d;
    logic                        wren_q, wren_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [ADDR_W-1:0]           key_el;

    ksa_key_sel #(
        .ADDR_W    (ADDR_W),
        .KEY_BYTES (KEY_BYTES)
    ) u_key_sel (
        .key_i  (key_q),
        .k_i    (k_q),
        .elem_o (key_el)
    );

    // Outputs are computed for the state being entered, so they line up with it.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        key_d   = key_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wren_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start) begin
                    key_d  = key;
                    i_d    = '0;
                    j_d    = '0;
                    k_d    = '0;
                    busy_d = 1'b1;
                    addr_d = '0;
                    if (skip_init) begin
                        state_d = StSwRi;
                    end else begin
                        state_d = StInit;
                        wren_d  = 1'b1;
                        wdata_d = '0;
                    end
                end
            end
            StInit: begin
                if (i_q == '1) begin
                    i_d     = '0;
                    addr_d  = '0;
                    state_d = StSwRi;
                end else begin
                    i_d     = i_q + 1'b1;
                    wren_d  = 1'b1;
                    addr_d  = i_d;
                    wdata_d = i_d;
                end
            end
            StSwRi: state_d = StSwLi;
            StSwLi: begin
                si_d    = mem.mem_rd_data;
                j_d     = ADDR_W'({2'b00, j_q} + {2'b00, mem.mem_rd_data} + {2'b00, key_el});
                addr_d  = j_d;
                state_d = StSwRj;
            end
            StSwRj: state_d = StSwLj;
            StSwLj: begin
                // S[j] goes straight into the write-data register for the S[i] write.
                wren_d  = 1'b1;
                addr_d  = i_q;
                wdata_d = mem.mem_rd_data;
                state_d = StSwWi;
            end
            StSwWi: begin
                wren_d  = 1'b1;
                addr_d  = j_q;
                wdata_d = si_q;
                state_d = StSwWj;
            end
            StSwWj: begin
                i_d = i_q + 1'b1;
                k_d = (k_q == KeyIdxW'(KEY_BYTES - 1)) ? '0 : k_q + 1'b1;
                if (i_q == '1) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    addr_d  = i_d;
                    state_d = StSwRi;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            key_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wren_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            key_q   <= key_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wren_q  <= wren_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_wr_data = wdata_q;
    assign mem.mem_wr_en   = wren_q;

endmodule

// File: tb/tb_ksa_sched.sv
// Scoreboard bench for ksa_sched: a 4-entry/1-byte-key instance and a default
// 256-entry/3-byte-key instance, each with its own behavioural S-memory.
module tb_ksa_sched;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       s_start = 1'b0, s_skip = 1'b0, s_busy, s_done;
    logic [1:0] s_key   = '0;
    logic       b_start = 1'b0, b_skip = 1'b0, b_busy, b_done;
    logic [23:0] b_key  = '0;
    logic [1:0] s_q;
    logic [7:0] b_q;

    ksa_sched_if #(.ADDR_W(2)) s_if ();
    ksa_sched_if #(.ADDR_W(8)) b_if ();

    ksa_sched #(.ADDR_W(2), .KEY_BYTES(1)) u_small (
        .clk(clk), .reset_n(reset_n), .start(s_start), .skip_init(s_skip), .key(s_key),
        .busy(s_busy), .done(s_done), .mem(s_if.master)
    );

    ksa_sched #(.ADDR_W(8), .KEY_BYTES(3)) u_big (
        .clk(clk), .reset_n(reset_n), .start(b_start), .skip_init(b_skip), .key(b_key),
        .busy(b_busy), .done(b_done), .mem(b_if.master)
    );

    assign s_if.mem_rd_data = s_q;
    assign b_if.mem_rd_data = b_q;

    // Synchronous single-port RAMs; q shows the pre-write contents.
    int unsigned mem [2][256];
    always @(posedge clk) begin
        s_q <= 2'(mem[0][s_if.mem_addr]);
        b_q <= 8'(mem[1][b_if.mem_addr]);
        if (s_if.mem_wr_en) mem[0][s_if.mem_addr] = 32'(s_if.mem_wr_data);
        if (b_if.mem_wr_en) mem[1][b_if.mem_addr] = 32'(b_if.mem_wr_data);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Expectation records per run: busy cycles, init flag, then DEPTH final S values.
    int eq0[$];
    int eq1[$];

    function automatic void q_push(input int sel, input int v);
        if (sel == 1) eq1.push_back(v);
        else eq0.push_back(v);
    endfunction

    function automatic int q_size(input int sel);
        return (sel == 1) ? eq1.size() : eq0.size();
    endfunction

    function automatic int q_peek(input int sel, input int idx);
        return (sel == 1) ? eq1[idx] : eq0[idx];
    endfunction

    function automatic int q_pop(input int sel);
        if (sel == 1) return eq1.pop_front();
        return eq0.pop_front();
    endfunction

    // Reference: textbook RC4 KSA on an array, key index taken as i mod key length.
    int unsigned model_s [2][256];
    int unsigned ref_key [3];

    task automatic ref_ksa(input int sel, input int unsigned depth, input int unsigned nk,
                           input bit skip);
        int unsigned j;
        int unsigned t;
        j = 0;
        if (!skip) for (int unsigned i = 0; i < depth; i++) model_s[sel][i] = i;
        for (int unsigned i = 0; i < depth; i++) begin
            j = (j + model_s[sel][i] + ref_key[i % nk]) % depth;
            t = model_s[sel][i];
            model_s[sel][i] = model_s[sel][j];
            model_s[sel][j] = t;
        end
    endtask

    function automatic int unsigned prga_first();
        int unsigned s [256];
        int unsigned j;
        int unsigned t;
        for (int a = 0; a < 256; a++) s[a] = mem[1][a];
        j = s[1];
        t = s[1];
        s[1] = s[j];
        s[j] = t;
        return s[(s[1] + s[j]) % 256];
    endfunction

    int busy_cnt [2];
    bit prev_done [2];

    task automatic mon(input int sel, input logic busy, input logic done, input logic wren,
                       input int addr, input int data);
        int depth;
        int exp_busy;
        int exp_v;
        int bad_idx;
        int bad_act;
        int bad_exp;
        bit init;
        depth = (sel == 1) ? 256 : 4;
        if (prev_done[sel]) chk(!busy && !done, "done_single_pulse", int'({busy, done}), 0);
        prev_done[sel] = done;
        if (!busy) begin
            busy_cnt[sel] = 0;
            if (done) chk(1'b0, "done_without_busy", 1, 0);
        end else begin
            busy_cnt[sel]++;
            if (q_size(sel) > 0) begin
                init = q_peek(sel, 1) != 0;
                if (init && busy_cnt[sel] <= depth)
                    chk(wren && addr == busy_cnt[sel] - 1 && data == busy_cnt[sel] - 1,
                        "init_write_addr", addr, busy_cnt[sel] - 1);
                if (!init && busy_cnt[sel] == 1)
                    chk(!wren && addr == 0, "skip_first_read_addr", addr, 0);
            end
            if (done) begin
                if (q_size(sel) < depth + 2) begin
                    chk(1'b0, "unexpected_done", busy_cnt[sel], 0);
                end else begin
                    exp_busy = q_pop(sel);
                    void'(q_pop(sel));
                    chk(busy_cnt[sel] == exp_busy, "busy_cycles", busy_cnt[sel], exp_busy);
                    bad_idx = -1;
                    bad_act = 0;
                    bad_exp = 0;
                    for (int a = 0; a < depth; a++) begin
                        exp_v = q_pop(sel);
                        if (bad_idx < 0 && mem[sel][a] != 32'(exp_v)) begin
                            bad_idx = a;
                            bad_act = int'(mem[sel][a]);
                            bad_exp = exp_v;
                        end
                    end
                    chk(bad_idx < 0, "s_contents", bad_act, bad_exp);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, s_busy, s_done, s_if.mem_wr_en, int'(s_if.mem_addr), int'(s_if.mem_wr_data));
        mon(1, b_busy, b_done, b_if.mem_wr_en, int'(b_if.mem_addr), int'(b_if.mem_wr_data));
    end

    task automatic run(input int sel, input bit skip, input logic [23:0] kb, input bit hammer);
        int unsigned depth;
        int unsigned nk;
        int n;
        bit busy_now;
        depth = (sel == 1) ? 256 : 4;
        nk    = (sel == 1) ? 3 : 1;
        for (int k = 0; k < 3; k++) ref_key[k] = 0;
        if (sel == 1) for (int k = 0; k < 3; k++) ref_key[k] = 32'(kb[(2 - k) * 8 +: 8]);
        else ref_key[0] = 32'(kb[1:0]);
        ref_ksa(sel, depth, nk, skip);
        q_push(sel, int'((skip ? 0 : depth) + 6 * depth + 1));
        q_push(sel, skip ? 0 : 1);
        for (int unsigned a = 0; a < depth; a++) q_push(sel, int'(model_s[sel][a]));
        @(negedge clk);
        if (sel == 1) begin
            b_start = 1'b1; b_skip = skip; b_key = kb;
        end else begin
            s_start = 1'b1; s_skip = skip; s_key = kb[1:0];
        end
        @(negedge clk);
        s_start = 1'b0;
        b_start = 1'b0;
        s_key   = 2'($urandom);
        b_key   = 24'($urandom);
        for (n = 0; n < 2000; n++) begin
            busy_now = (sel == 1) ? b_busy : s_busy;
            if (!busy_now) break;
            if (hammer) begin
                b_start = 1'b1;
                b_key   = 24'($urandom);
            end
            @(negedge clk);
        end
        b_start = 1'b0;
        if (n == 2000) chk(1'b0, "run_timeout", n, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk(!s_busy && !s_done && !s_if.mem_wr_en, "small_reset_ctrl",
            int'({s_busy, s_done, s_if.mem_wr_en}), 0);
        chk(s_if.mem_addr == 0 && s_if.mem_wr_data == 0, "small_reset_bus",
            int'({s_if.mem_addr, s_if.mem_wr_data}), 0);
        chk(!b_busy && !b_done && !b_if.mem_wr_en, "big_reset_ctrl",
            int'({b_busy, b_done, b_if.mem_wr_en}), 0);
        chk(b_if.mem_addr == 0 && b_if.mem_wr_data == 0, "big_reset_bus",
            int'({b_if.mem_addr, b_if.mem_wr_data}), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // 4-entry instance: hand-checked key 01 run, then skip-init on its result.
        run(0, 1'b0, 24'h000001, 1'b0);
        chk(mem[0][0] == 0 && mem[0][1] == 2 && mem[0][2] == 3 && mem[0][3] == 1,
            "scen1_final_s",
            int'(mem[0][0] * 64 + mem[0][1] * 16 + mem[0][2] * 4 + mem[0][3]), 45);
        run(0, 1'b1, 24'h000001, 1'b0);
        repeat (20) run(0, 1'($urandom_range(0, 1)), 24'($urandom_range(0, 3)), 1'b0);

        // 256-entry instance.
        run(1, 1'b0, 24'h000000, 1'b0);
        run(1, 1'b0, 24'h4B6579, 1'b0);
        chk(prga_first() == 32'hEB, "prga_first_byte", int'(prga_first()), 'hEB);
        run(1, 1'b0, 24'h4B6579, 1'b1);

        // Abort in SW_LJ of the first index: cycle 260 of a run with init.
        @(negedge clk);
        b_start = 1'b1;
        b_skip  = 1'b0;
        b_key   = 24'($urandom);
        @(negedge clk);
        b_start = 1'b0;
        repeat (259) @(negedge clk);
        chk(b_busy && !b_if.mem_wr_en, "pre_abort_busy", int'({b_busy, b_if.mem_wr_en}), 2);
        reset_n = 1'b0;
        #1;
        chk(!b_busy && !b_done && !b_if.mem_wr_en, "abort_ctrl",
            int'({b_busy, b_done, b_if.mem_wr_en}), 0);
        chk(b_if.mem_addr == 0, "abort_addr", int'(b_if.mem_addr), 0);
        @(negedge clk);
        reset_n = 1'b1;

        run(1, 1'b0, 24'($urandom), 1'b0);
        run(1, 1'b1, 24'($urandom), 1'b0);

        repeat (4) @(negedge clk);
        chk(q_size(0) == 0 && q_size(1) == 0, "pending_expectations", q_size(0) + q_size(1), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ksa_sched.md
Name: ksa_sched

Overview:
Parametrised RC4-style key-scheduling engine that drives a single-port synchronous S-memory.
- Phase 1 (optional): initialises S[i] = i for every address.
- Phase 2: runs the key-scheduling swap loop j = j + S[i] + key[i mod KEY_BYTES], swapping S[i] and S[j].
- Successor to the fixed 256-entry init-only writer. Adds generic depth/key length, key scheduling, a start/busy/done handshake and an init-skip mode.
- Sits between the top-level control and the S-memory instance.

Parameters:
ADDR_W, 8, address width and S-element width; DEPTH = 2**ADDR_W; all index arithmetic is mod DEPTH
KEY_BYTES, 3, number of key elements, each ADDR_W bits wide; legal range 1..DEPTH

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
skip_init  in  1  sampled with start; 1 = skip phase 1 and use existing S contents
key  in  KEY_BYTES*ADDR_W  key; element k = key[(KEY_BYTES-1-k)*ADDR_W +: ADDR_W], so element 0 is the MSBs
busy  out  1  high from the cycle after start is accepted through the DONE cycle inclusive
done  out  1  one-cycle pulse in the DONE state
mem_addr  out  ADDR_W  S-memory address
mem_wr_data  out  ADDR_W  S-memory write data
mem_wr_en  out  1  S-memory write enable
mem_rd_data  in  ADDR_W  S-memory q; valid the cycle after mem_addr is presented with mem_wr_en=0

Behaviour:
- Reset (async, takes effect immediately): state IDLE; i, j, k, latched key and all outputs = 0. S-memory contents are undefined after a mid-operation reset; no recovery is attempted.
- IDLE:
  - start=1 latches key and skip_init.
  - Next state: INIT, or SW_RI if skip_init=1. i=j=k=0.
  - start while not in IDLE is ignored; the key input may change freely once latched.
- INIT (one write per cycle): mem_wr_en=1, mem_addr=i, mem_wr_data=i. After i=DEPTH-1 go to SW_RI with i wrapped to 0. Duration is exactly DEPTH cycles.
- Swap loop, 6 cycles per index:
  - SW_RI: mem_addr=i, wren=0.
  - SW_LI: latch si=mem_rd_data; compute j_next = j + si + key[k] (mod DEPTH) and register it into j.
  - SW_RJ: mem_addr=j, wren=0.
  - SW_LJ: latch sj=mem_rd_data.
  - SW_WI: wren=1, addr=i, data=sj.
  - SW_WJ: wren=1, addr=j, data=si.
    - Then i=i+1 and k=(k==KEY_BYTES-1)?0:k+1. k is a rolling counter; no divider.
    - Next state: SW_RI, or DONE if i was DEPTH-1.
- i==j case: both writes carry the same value; no special case is needed; S is unchanged.
- DONE: done=1 and busy=1 for one cycle, then IDLE (busy=0).
- Non-write cycles: mem_wr_en=0; mem_wr_data holds its last value.
- Total busy cycles:
  - DEPTH + 6*DEPTH + 1 with init (1793 at defaults).
  - 6*DEPTH + 1 with skip_init.
- Width rules:
  - j addition is computed ADDR_W+2 bits wide and truncated to ADDR_W.
  - i and k counters wrap naturally.
  - No output is X after reset.

Decomposition:
- Package ksa_pkg:
  - State enum: IDLE, INIT, SW_RI, SW_LI, SW_RJ, SW_LJ, SW_WI, SW_WJ, DONE.
  - Default ADDR_W and KEY_BYTES constants.
  - Function key_elem(key, k) for element extraction.
- One sub-module: ksa_key_sel, combinational.
  - Inputs: latched key, k.
  - Output: key element k.
  - Reused by the later decrypt stage.
- FSM, counters and datapath registers stay in ksa_sched.

Test Plan:
1. ADDR_W=2, KEY_BYTES=1, key=2'b01, start, skip_init=0 -> writes 0,1,2,3 to addrs 0..3, then final S=[0,2,3,1]; busy for 29 cycles; single done pulse.
2. Defaults with key=24'h000000 -> after INIT, S equals the software RC4 KSA model for key {00,00,00}; check all 256 entries; busy exactly 1793 cycles.
3. Defaults with key=24'h4B6579 ("Key") -> S matches the software model. First PRGA byte from a bench-side PRGA equals 0xEB.
4. Preload S with the scenario-1 result, skip_init=1, key=2'b01 -> no INIT writes; first mem_addr after start is 0 with wren=0; busy 25 cycles; S matches the model run on the preloaded contents.
5. Assert start every cycle during busy, and change key mid-run -> ignored; result identical to scenario 3.
6. Drop reset_n during SW_LJ -> same-cycle busy=done=wren=0, state IDLE. A following start with fresh init yields the correct S.
